regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file: configurable width, depth and read-port count.
- Adds a hard-wired zero register, write-to-read bypass, optional registered (1-cycle) reads, and a per-register busy scoreboard.
- Sits between decode/issue (read, reserve) and writeback (write, release) in the pipelined RV32I core.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, ≥2. Localparam AW = clog2(NREGS).
- NUM_RD, 2, number of read ports, ≥1.
- REG_RD, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.

Ports:
- clkin  in  1  clock, all state updates on rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- wr_en  in  1  writeback strobe.
- wr_idx_in  in  AW  writeback register index.
- wr_data_in  in  XLEN  writeback data.
- rd_idx_in  in  NUM_RD*AW  read indices; port k occupies bits [k*AW +: AW].
- rd_data_out  out  NUM_RD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rd_busy_out  out  NUM_RD  port k's register has a pending producer.
- rsv_en  in  1  reserve request: mark a destination register busy.
- rsv_idx_in  in  AW  register to reserve.
- rsv_stall_out  out  1  reservation refused this cycle (WAW hazard).
- busy_cnt_out  out  AW+1  number of currently busy registers.

Behaviour:
- Reset: at a posedge with rst_in=1:
  - all registers and busy bits clear to 0; busy_cnt_out becomes 0.
  - with REG_RD=1, rd_data_out and rd_busy_out become 0.
  - reset dominates any concurrent wr_en or rsv_en.
- Write: at a posedge with wr_en=1, regs[wr_idx_in] <= wr_data_in. Suppressed when ZERO_REG=1 and wr_idx_in=0.
- Combinational read value for port k (idx = index for port k):
  - 0 if ZERO_REG=1 and idx=0;
  - else wr_data_in if BYPASS=1, wr_en=1 and wr_idx_in=idx;
  - else regs[idx].
- REG_RD=0: rd_data_out and rd_busy_out are that combinational value. Latency 0.
- REG_RD=1: that value is captured each posedge and presented the following cycle. Latency 1, no enable.
- Busy bit for a register:
  - set at a posedge when rsv_en=1, the index is rsv_idx_in and rsv_stall_out=0;
  - cleared at a posedge when wr_en=1 with that index.
  - Simultaneous set and clear on the same index: set wins, because a new producer has been issued.
- rd_busy_out[k] = busy[idx] AND NOT (BYPASS=1 AND wr_en=1 AND wr_idx_in=idx). Forced 0 for idx 0 when ZERO_REG=1.
- rsv_stall_out = rsv_en AND busy[rsv_idx_in] AND NOT (wr_en AND wr_idx_in=rsv_idx_in). Purely combinational.
  - A stalled reservation changes no state; the requester holds its request and retries.
- Reserve of index 0 with ZERO_REG=1: accepted, no stall, no state change.
- Write to a register that is not busy: data is written; busy state unchanged. Legal, no error.
- busy_cnt_out is a registered counter:
  - +1 on an accepted set of a non-busy bit;
  - -1 on a clear of a busy bit;
  - net 0 when both occur in the same cycle;
  - always equals the popcount of the busy bits; never exceeds NREGS-ZERO_REG.
- Out-of-range indices are impossible because NREGS is a power of two.

Decomposition:
- Shared package core_pkg holds XLEN, NREGS, the AW localparam, and a register-index typedef reused by decode and writeback.
- One natural sub-module, regfile_sb_scoreboard: busy bits, stall logic and busy counter.
- The parent keeps storage, bypass muxes and the REG_RD output register.

Test Plan:
- Reset then read, REG_RD=0: rst_in=1 for one cycle, then rd_idx 5 and 31 -> rd_data 0, rd_busy 0, busy_cnt 0.
- Write then read: wr_en, idx 3, data 0xDEADBEEF; next cycle read idx 3 -> 0xDEADBEEF.
- Zero register: write idx 0 with data 0x12345678, then read idx 0 -> 0.
- Bypass: in the same cycle, wr_en idx 7 data 0xA5A5A5A5 and read idx 7.
  - BYPASS=1 -> 0xA5A5A5A5 that cycle.
  - BYPASS=0 -> old value that cycle, new value the next cycle.
  - REG_RD=1 -> 0xA5A5A5A5 one cycle later.
- Scoreboard:
  - rsv idx 9 -> busy_cnt 1; rd_busy 1 for idx 9.
  - rsv idx 9 again -> rsv_stall 1, busy_cnt still 1.
  - rsv idx 9 together with wr idx 9 -> no stall; busy bit stays 1; busy_cnt stays 1.
  - wr idx 9 alone -> busy_cnt 0.
- Reset mid-operation: reserve idx 4 and 6 (busy_cnt 2), then rst_in=1 with wr_en and rsv_en also asserted -> all busy bits 0, busy_cnt 0, register data 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default integer register file geometry and the
// register-index type used by decode, issue and writeback.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Register file bus: writeback, read ports and reservation, seen from the
// issue/writeback side (master) and from the register file (slave).
interface regfile_sb_if #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int NREGS  = core_pkg::NREGS,
  parameter int NUM_RD = 2
);

  localparam int AW = $clog2(NREGS);

  logic                     wr_en;
  logic [AW-1:0]            wr_idx_in;
  logic [XLEN-1:0]          wr_data_in;
  logic [NUM_RD*AW-1:0]     rd_idx_in;
  logic [NUM_RD*XLEN-1:0]   rd_data_out;
  logic [NUM_RD-1:0]        rd_busy_out;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_idx_in;
  logic                     rsv_stall_out;
  logic [AW:0]              busy_cnt_out;

  modport master (
    output wr_en, wr_idx_in, wr_data_in, rd_idx_in, rsv_en, rsv_idx_in,
    input  rd_data_out, rd_busy_out, rsv_stall_out, busy_cnt_out
  );

  modport slave (
    input  wr_en, wr_idx_in, wr_data_in, rd_idx_in, rsv_en, rsv_idx_in,
    output rd_data_out, rd_busy_out, rsv_stall_out, busy_cnt_out
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy tracking: reservation from issue, release on writeback,
// WAW stall and a running count of busy registers.
module regfile_sb_scoreboard #(
  parameter int NREGS    = core_pkg::NREGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_idx_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_idx_i,
  input  logic [NUM_RD*AW-1:0] rd_idx_i,
  output logic [NUM_RD-1:0]    rd_busy_o,
  output logic                 rsv_stall_o,
  output logic [AW:0]          busy_cnt_o
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_live, wr_hit_rsv, rsv_set, inc, dec;
  logic [AW-1:0]    rd_sel;

  always_comb begin
    wr_live     = wr_en_i && !(ZERO_REG != 0 && wr_idx_i == '0);
    wr_hit_rsv  = wr_en_i && (wr_idx_i == rsv_idx_i);
    rsv_stall_o = rsv_en_i && busy_q[rsv_idx_i] && !wr_hit_rsv;
    rsv_set     = rsv_en_i && !rsv_stall_o && !(ZERO_REG != 0 && rsv_idx_i == '0);
    inc         = rsv_set && !busy_q[rsv_idx_i];
    // A release that coincides with a new reservation of the same register keeps the bit set.
    dec         = wr_live && busy_q[wr_idx_i] && !(rsv_set && wr_hit_rsv);

    busy_d = busy_q;
    if (wr_live) busy_d[wr_idx_i] = 1'b0;
    if (rsv_set) busy_d[rsv_idx_i] = 1'b1;

    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + CNT_ONE;
    else if (dec && !inc) cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    rd_busy_o = '0;
    rd_sel    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_sel       = rd_idx_i[k*AW +: AW];
      rd_busy_o[k] = busy_q[rd_sel] && !(BYPASS != 0 && wr_en_i && wr_idx_i == rd_sel);
      if (ZERO_REG != 0 && rd_sel == '0) rd_busy_o[k] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with zero register, write-to-read
// bypass, optional registered reads and a busy scoreboard.
module regfile_sb #(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int NREGS    = core_pkg::NREGS,
  parameter int NUM_RD   = 2,
  parameter int REG_RD   = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic         clkin,
  input  logic         rst_in,
  regfile_sb_if.slave  bus
);

  logic [XLEN-1:0]        regs_q [NREGS];
  logic                   wr_live;
  logic [AW-1:0]          rd_sel;
  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]      rd_busy_c;

  assign wr_live = bus.wr_en && !(ZERO_REG != 0 && bus.wr_idx_in == '0);

  always_ff @(posedge clkin) begin
    if (rst_in) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[bus.wr_idx_in] <= bus.wr_data_in;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_sel    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_sel = bus.rd_idx_in[k*AW +: AW];
      if (ZERO_REG != 0 && rd_sel == '0)
        rd_data_c[k*XLEN +: XLEN] = '0;
      else if (BYPASS != 0 && bus.wr_en && bus.wr_idx_in == rd_sel)
        rd_data_c[k*XLEN +: XLEN] = bus.wr_data_in;
      else
        rd_data_c[k*XLEN +: XLEN] = regs_q[rd_sel];
    end
  end

  regfile_sb_scoreboard #(
    .NREGS    (NREGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i       (clkin),
    .rst_i       (rst_in),
    .wr_en_i     (bus.wr_en),
    .wr_idx_i    (bus.wr_idx_in),
    .rsv_en_i    (bus.rsv_en),
    .rsv_idx_i   (bus.rsv_idx_in),
    .rd_idx_i    (bus.rd_idx_in),
    .rd_busy_o   (rd_busy_c),
    .rsv_stall_o (bus.rsv_stall_out),
    .busy_cnt_o  (bus.busy_cnt_out)
  );

  generate
    if (REG_RD != 0) begin : g_reg_rd
      logic [NUM_RD*XLEN-1:0] rd_data_q;
      logic [NUM_RD-1:0]      rd_busy_q;

      // Read stage: capture the bypassed read value, presented one cycle later.
      always_ff @(posedge clkin) begin
        if (rst_in) begin
          rd_data_q <= '0;
          rd_busy_q <= '0;
        end else begin
          rd_data_q <= rd_data_c;
          rd_busy_q <= rd_busy_c;
        end
      end

      assign bus.rd_data_out = rd_data_q;
      assign bus.rd_busy_out = rd_busy_q;
    end else begin : g_comb_rd
      assign bus.rd_data_out = rd_data_c;
      assign bus.rd_busy_out = rd_busy_c;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: combinational/bypass, registered-read and
// no-bypass instances driven by the same directed vectors.
module tb_regfile_sb;
  import core_pkg::*;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          we;
    int          wi;
    logic [31:0] wd;
    bit          re;
    int          ri;
    int          r0;
    int          r1;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          b0;
    bit          b1;
    bit          st;
    int          cnt;
    logic [31:0] nd0;
    bit          nb0;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          b0;
    bit          b1;
    bit          st;
    int          cnt;
    logic [31:0] nd0;
    bit          nb0;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];
  exp_t q_cmb[$];
  exp_t q_reg[$];
  exp_t mc, mr;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2)) if_cmb ();
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2)) if_reg ();
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2)) if_nb ();

  assign if_reg.wr_en      = if_cmb.wr_en;
  assign if_reg.wr_idx_in  = if_cmb.wr_idx_in;
  assign if_reg.wr_data_in = if_cmb.wr_data_in;
  assign if_reg.rd_idx_in  = if_cmb.rd_idx_in;
  assign if_reg.rsv_en     = if_cmb.rsv_en;
  assign if_reg.rsv_idx_in = if_cmb.rsv_idx_in;
  assign if_nb.wr_en       = if_cmb.wr_en;
  assign if_nb.wr_idx_in   = if_cmb.wr_idx_in;
  assign if_nb.wr_data_in  = if_cmb.wr_data_in;
  assign if_nb.rd_idx_in   = if_cmb.rd_idx_in;
  assign if_nb.rsv_en      = if_cmb.rsv_en;
  assign if_nb.rsv_idx_in  = if_cmb.rsv_idx_in;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2), .REG_RD(0), .BYPASS(1), .ZERO_REG(1))
    u_cmb (.clkin(clk), .rst_in(rst), .bus(if_cmb));
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2), .REG_RD(1), .BYPASS(1), .ZERO_REG(1))
    u_reg (.clkin(clk), .rst_in(rst), .bus(if_reg));
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2), .REG_RD(0), .BYPASS(0), .ZERO_REG(1))
    u_nb (.clkin(clk), .rst_in(rst), .bus(if_nb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input bit chk, input bit rs, input bit we, input int wi, input logic [31:0] wd,
                     input bit re, input int ri, input int r0, input int r1,
                     input logic [31:0] d0, input logic [31:0] d1, input bit b0, input bit b1,
                     input bit st, input int cnt, input logic [31:0] nd0, input bit nb0);
    vec_t v;
    v.chk = chk; v.rst = rs; v.we = we; v.wi = wi; v.wd = wd; v.re = re; v.ri = ri;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.st = st;
    v.cnt = cnt; v.nd0 = nd0; v.nb0 = nb0;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s v%0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  // Monitor: one expected entry per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q_cmb.size() > 0) begin
      mc = q_cmb.pop_front();
      cmp("cmb_d0",  mc.idx, if_cmb.rd_data_out[XLEN-1:0],      mc.d0);
      cmp("cmb_d1",  mc.idx, if_cmb.rd_data_out[2*XLEN-1:XLEN], mc.d1);
      cmp("cmb_b0",  mc.idx, 32'(if_cmb.rd_busy_out[0]),        32'(mc.b0));
      cmp("cmb_b1",  mc.idx, 32'(if_cmb.rd_busy_out[1]),        32'(mc.b1));
      cmp("cmb_st",  mc.idx, 32'(if_cmb.rsv_stall_out),         32'(mc.st));
      cmp("cmb_cnt", mc.idx, 32'(if_cmb.busy_cnt_out),          mc.cnt);
      cmp("nb_d0",   mc.idx, if_nb.rd_data_out[XLEN-1:0],       mc.nd0);
      cmp("nb_b0",   mc.idx, 32'(if_nb.rd_busy_out[0]),         32'(mc.nb0));
      cmp("nb_cnt",  mc.idx, 32'(if_nb.busy_cnt_out),           mc.cnt);
    end
    if (q_reg.size() > 0) begin
      mr = q_reg.pop_front();
      cmp("reg_d0",  mr.idx, if_reg.rd_data_out[XLEN-1:0],      mr.d0);
      cmp("reg_d1",  mr.idx, if_reg.rd_data_out[2*XLEN-1:XLEN], mr.d1);
      cmp("reg_b0",  mr.idx, 32'(if_reg.rd_busy_out[0]),        32'(mr.b0));
      cmp("reg_b1",  mr.idx, 32'(if_reg.rd_busy_out[1]),        32'(mr.b1));
      cmp("reg_st",  mr.idx, 32'(if_reg.rsv_stall_out),         32'(mr.st));
      cmp("reg_cnt", mr.idx, 32'(if_reg.busy_cnt_out),          mr.cnt);
    end
  end

  initial begin
    exp_t ec, er;
    vec_t v, pv;
    n_vec = 0;
    n_err = 0;
    //  chk rst we wi wdata         re ri r0 r1  d0            d1            b0 b1 st cnt nd0           nb0
    add(0, 1, 0, 0, 32'h0,        0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        0, 0, 5, 31, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 1, 3, 32'hDEADBEEF, 0, 0, 3, 0,  32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        0, 0, 3, 7,  32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 0);
    add(1, 0, 1, 0, 32'h12345678, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        0, 0, 0, 3,  32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 3,  32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        0, 0, 7, 0,  32'hA5A5A5A5, 32'h0,        0, 0, 0, 0, 32'hA5A5A5A5, 0);
    add(1, 0, 0, 0, 32'h0,        1, 9, 9, 7,  32'h0,        32'hA5A5A5A5, 0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        0, 0, 9, 7,  32'h0,        32'hA5A5A5A5, 1, 0, 0, 1, 32'h0,        1);
    add(1, 0, 0, 0, 32'h0,        1, 9, 9, 7,  32'h0,        32'hA5A5A5A5, 1, 0, 1, 1, 32'h0,        1);
    add(1, 0, 0, 0, 32'h0,        0, 0, 9, 0,  32'h0,        32'h0,        1, 0, 0, 1, 32'h0,        1);
    add(1, 0, 1, 9, 32'h11112222, 1, 9, 9, 9,  32'h11112222, 32'h11112222, 0, 0, 0, 1, 32'h0,        1);
    add(1, 0, 0, 0, 32'h0,        0, 0, 9, 0,  32'h11112222, 32'h0,        1, 0, 0, 1, 32'h11112222, 1);
    add(1, 0, 1, 9, 32'h33334444, 0, 0, 9, 3,  32'h33334444, 32'hDEADBEEF, 0, 0, 0, 1, 32'h11112222, 1);
    add(1, 0, 0, 0, 32'h0,        0, 0, 9, 3,  32'h33334444, 32'hDEADBEEF, 0, 0, 0, 0, 32'h33334444, 0);
    add(1, 0, 0, 0, 32'h0,        1, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        1, 4, 0, 0,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        1, 6, 4, 6,  32'h0,        32'h0,        1, 0, 0, 1, 32'h0,        1);
    add(1, 1, 1, 6, 32'hFFFF0000, 1, 4, 4, 6,  32'h0,        32'hFFFF0000, 1, 0, 1, 2, 32'h0,        1);
    add(1, 0, 0, 0, 32'h0,        0, 0, 4, 6,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        0, 0, 3, 7,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        0, 0, 9, 31, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);

    rst = 1'b0;
    if_cmb.wr_en = 1'b0; if_cmb.wr_idx_in = '0; if_cmb.wr_data_in = '0;
    if_cmb.rd_idx_in = '0; if_cmb.rsv_en = 1'b0; if_cmb.rsv_idx_in = '0;
    pv = vecs[0];
    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      v = vecs[i];
      rst               = v.rst;
      if_cmb.wr_en      = v.we;
      if_cmb.wr_idx_in  = reg_idx_t'(v.wi);
      if_cmb.wr_data_in = v.wd;
      if_cmb.rsv_en     = v.re;
      if_cmb.rsv_idx_in = reg_idx_t'(v.ri);
      if_cmb.rd_idx_in  = {reg_idx_t'(v.r1), reg_idx_t'(v.r0)};
      if (v.chk) begin
        ec.idx = i; ec.d0 = v.d0; ec.d1 = v.d1; ec.b0 = v.b0; ec.b1 = v.b1;
        ec.st = v.st; ec.cnt = v.cnt; ec.nd0 = v.nd0; ec.nb0 = v.nb0;
        q_cmb.push_back(ec);
      end
      // Registered reads show the previous cycle's bypassed value (zero after reset).
      if (i > 0 && v.chk && (pv.rst || pv.chk)) begin
        er.idx = i;
        er.d0  = pv.rst ? 32'h0 : pv.d0;
        er.d1  = pv.rst ? 32'h0 : pv.d1;
        er.b0  = pv.rst ? 1'b0 : pv.b0;
        er.b1  = pv.rst ? 1'b0 : pv.b1;
        er.st  = v.st; er.cnt = v.cnt; er.nd0 = 32'h0; er.nb0 = 1'b0;
        q_reg.push_back(er);
      end
      pv = v;
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    if_cmb.wr_en = 1'b0; if_cmb.rsv_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
